// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
//
// Purpose:
//   Hazard-detection stage sitting beside decode. It shadows the EX, MEM and
//   WB stages with a 3-slot pipeline of in-flight register writers. When a
//   decode-stage source register matches a pending write that cannot be
//   forwarded, it raises `stall`: PC and IF/ID hold, and a bubble goes into
//   ID/EX (the shadow EX slot is loaded with an empty entry in the same cycle).
//   It also counts stall cycles with a saturating counter and exports a
//   pending-write mask for debug.
//
// Parameters:
//   FORWARD  1: EX/MEM forwarding exists, so only a load in EX stalls a reader.
//            0: no forwarding, so any writer in EX or MEM stalls a reader.
//   CNT_W    width of the stall-cycle counter.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   id_valid            decode holds a real instruction (not a bubble)
//   id_Rs/id_RsValid    source 1 index and "is read" flag
//   id_Rt/id_RtValid    source 2 index and "is read" flag
//   id_writeRegValid    decoder write flag (also set for stores)
//   id_isStore          instruction is ST/STU
//   id_isLoad           instruction is LD
//   id_writeReg         destination register index
//   flush               taken branch/jump: squash the decode instruction
//   stall               hold PC and IF/ID, inject a bubble into ID/EX
//   pending_mask        bit r set while EX or MEM holds a valid writer of r
//   stall_cnt           number of stalled cycles, saturating at all-ones
//
// Handshake: there is no valid/ready pair here. `stall` acts as the "not ready"
// for the decode stage: the decode instruction advances into EX on a clock edge
// only when id_valid=1, stall=0 and flush=0; otherwise EX receives a bubble.
// -----------------------------------------------------------------------------
module hazard_scoreboard #(
  parameter bit FORWARD = 1'b1,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [2:0]       id_Rs,
  input  logic [2:0]       id_Rt,
  input  logic             id_RsValid,
  input  logic             id_RtValid,
  input  logic             id_writeRegValid,
  input  logic             id_isStore,
  input  logic             id_isLoad,
  input  logic [2:0]       id_writeReg,
  input  logic             flush,
  output logic             stall,
  output logic [7:0]       pending_mask,
  output logic [CNT_W-1:0] stall_cnt
);

  // One shadow-pipeline entry: valid writer, destination register, is-load.
  typedef struct packed {
    logic       v;
    logic [2:0] rg;
    logic       ld;
  } slot_t;

  slot_t            ex_q, mem_q, wb_q;
  slot_t            ex_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic w;      // decode instruction is a real register writer
  logic m_ex;   // decode source matches the writer in EX
  logic m_mem;  // decode source matches the writer in MEM

  // Stores carry id_writeRegValid but only write memory, so they are excluded.
  assign w = id_valid & id_writeRegValid & ~id_isStore;

  // Only older instructions (slots) are compared; the decode instruction's own
  // destination is never checked against its own sources.
  assign m_ex  = ex_q.v  & ((id_RsValid & (id_Rs == ex_q.rg)) |
                            (id_RtValid & (id_Rt == ex_q.rg)));
  assign m_mem = mem_q.v & ((id_RsValid & (id_Rs == mem_q.rg)) |
                            (id_RtValid & (id_Rt == mem_q.rg)));

  // WB is intentionally not consulted: the register file writes in the first
  // half of the cycle and reads in the second, so a WB producer is visible.
  // flush squashes the decode instruction, so it can never cause a stall.
  generate
    if (FORWARD) begin : g_fwd
      assign stall = id_valid & ~flush & m_ex & ex_q.ld;
    end else begin : g_nofwd
      assign stall = id_valid & ~flush & (m_ex | m_mem);
    end
  endgenerate

  // A stalled or squashed decode instruction is replaced by an empty entry.
  always_comb begin
    ex_d = '0;
    if (!stall && !flush) begin
      ex_d.v  = w;
      ex_d.rg = id_writeReg;
      ex_d.ld = id_isLoad & w;
    end
  end

  // Saturating stall counter: holds at all-ones instead of wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= ex_q;
      wb_q        <= mem_q;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Debug view of writers that still need forwarding or stalling (EX, MEM).
  always_comb begin
    pending_mask = '0;
    if (ex_q.v)  pending_mask[ex_q.rg]  = 1'b1;
    if (mem_q.v) pending_mask[mem_q.rg] = 1'b1;
  end

  assign stall_cnt = stall_cnt_q;

  // The WB slot mirrors the real pipeline for completeness but never gates a
  // stall; this keeps it referenced without affecting any output.
  logic unused_wb;
  assign unused_wb = ^wb_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_hazard_scoreboard
//
// Two instances: u_f1 (FORWARD=1, CNT_W=16) driven from a vector table, and
// u_f0 (FORWARD=0, CNT_W=4) driven by hand-written sequences, including stall
// counter saturation and reset in the middle of a hazard.
// Inputs change just after the falling edge; outputs are sampled 1 ns later,
// before the next rising edge. stall_cnt is the value registered so far.
// -----------------------------------------------------------------------------
module tb_hazard_scoreboard;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst;
    logic       valid;
    logic [2:0] rs;
    logic       rsv;
    logic [2:0] rt;
    logic       rtv;
    logic       wrv;
    logic       st;
    logic       ld;
    logic [2:0] wr;
    logic       flush;
  } in_t;

  typedef struct {
    in_t         i;
    bit          chk;
    logic        e_stall;
    logic [7:0]  e_mask;
    logic [15:0] e_cnt;
  } vec_t;

  in_t in1, in0;

  logic        stall1, stall0;
  logic [7:0]  mask1, mask0;
  logic [15:0] cnt1;
  logic [3:0]  cnt0;

  hazard_scoreboard #(.FORWARD(1'b1), .CNT_W(16)) u_f1 (
    .clk(clk), .rst(in1.rst), .id_valid(in1.valid),
    .id_Rs(in1.rs), .id_Rt(in1.rt), .id_RsValid(in1.rsv), .id_RtValid(in1.rtv),
    .id_writeRegValid(in1.wrv), .id_isStore(in1.st), .id_isLoad(in1.ld),
    .id_writeReg(in1.wr), .flush(in1.flush),
    .stall(stall1), .pending_mask(mask1), .stall_cnt(cnt1)
  );

  hazard_scoreboard #(.FORWARD(1'b0), .CNT_W(4)) u_f0 (
    .clk(clk), .rst(in0.rst), .id_valid(in0.valid),
    .id_Rs(in0.rs), .id_Rt(in0.rt), .id_RsValid(in0.rsv), .id_RtValid(in0.rtv),
    .id_writeRegValid(in0.wrv), .id_isStore(in0.st), .id_isLoad(in0.ld),
    .id_writeReg(in0.wr), .flush(in0.flush),
    .stall(stall0), .pending_mask(mask0), .stall_cnt(cnt0)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string nm, input logic [31:0] act);
    logic [31:0] e;
    e = exp_q.pop_front();
    total++;
    if (act !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, e);
    end
  endtask

  function automatic in_t ins(input logic v, input logic [2:0] rs, input logic rsv,
                              input logic [2:0] rt, input logic rtv, input logic wrv,
                              input logic st, input logic ld, input logic [2:0] wr,
                              input logic fl, input logic r);
    in_t t;
    t.rst = r; t.valid = v; t.rs = rs; t.rsv = rsv; t.rt = rt; t.rtv = rtv;
    t.wrv = wrv; t.st = st; t.ld = ld; t.wr = wr; t.flush = fl;
    return t;
  endfunction

  function automatic vec_t vv(input in_t i, input bit c, input logic s,
                              input logic [7:0] m, input logic [15:0] n);
    vec_t x;
    x.i = i; x.chk = c; x.e_stall = s; x.e_mask = m; x.e_cnt = n;
    return x;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step1(input vec_t x, input string nm);
    @(negedge clk);
    in1 = x.i;
    #1;
    if (x.chk) begin
      exp_q.push_back({31'd0, x.e_stall}); check({nm, " f1 stall"}, {31'd0, stall1});
      exp_q.push_back({24'd0, x.e_mask});  check({nm, " f1 mask"},  {24'd0, mask1});
      exp_q.push_back({16'd0, x.e_cnt});   check({nm, " f1 cnt"},   {16'd0, cnt1});
    end
  endtask

  task automatic step0(input in_t i, input bit c, input logic s,
                       input logic [7:0] m, input logic [3:0] n, input string nm);
    @(negedge clk);
    in0 = i;
    #1;
    if (c) begin
      exp_q.push_back({31'd0, s});  check({nm, " f0 stall"}, {31'd0, stall0});
      exp_q.push_back({24'd0, m});  check({nm, " f0 mask"},  {24'd0, mask0});
      exp_q.push_back({28'd0, n});  check({nm, " f0 cnt"},   {28'd0, cnt0});
    end
  endtask

  // ---------------- stimulus ----------------
  vec_t tbl[28];
  in_t  idle, rst_i, beqz, hz;

  initial begin
    idle  = ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_i = ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    in1 = rst_i;
    in0 = rst_i;

    //            v  rs rsv rt rtv wrv st ld wr fl rst        stall mask   cnt
    tbl[0]  = vv(ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1, 0, 8'h00, 0); // after reset
    tbl[1]  = vv(ins(1, 1, 1, 0, 0, 1, 0, 1, 3, 0, 0), 1, 0, 8'h00, 0); // LD r3
    tbl[2]  = vv(ins(1, 3, 1, 5, 1, 1, 0, 0, 4, 0, 0), 1, 1, 8'h08, 0); // ADD r4,r3,r5
    tbl[3]  = vv(ins(1, 3, 1, 5, 1, 1, 0, 0, 4, 0, 0), 1, 0, 8'h08, 1); // retry
    tbl[4]  = vv(ins(1, 0, 1, 0, 0, 1, 0, 0, 3, 0, 0), 1, 0, 8'h10, 1); // ADDI r3
    tbl[5]  = vv(ins(1, 3, 1, 3, 1, 1, 0, 0, 7, 0, 0), 1, 0, 8'h18, 1); // SUB r7,r3,r3
    tbl[6]  = vv(ins(1, 6, 1, 2, 1, 1, 1, 0, 6, 0, 0), 1, 0, 8'h88, 1); // ST r6
    tbl[7]  = vv(ins(1, 6, 1, 0, 0, 1, 0, 0, 5, 0, 0), 1, 0, 8'h80, 1); // ADD r5,r6
    tbl[8]  = vv(idle, 1, 0, 8'h20, 1);
    tbl[9]  = vv(idle, 1, 0, 8'h20, 1);
    tbl[10] = vv(idle, 1, 0, 8'h00, 1);
    tbl[11] = vv(ins(1, 2, 1, 0, 0, 1, 0, 1, 1, 0, 0), 1, 0, 8'h00, 1); // LD r1
    tbl[12] = vv(ins(1, 1, 1, 0, 0, 1, 0, 0, 2, 1, 0), 1, 0, 8'h02, 1); // dep + flush
    tbl[13] = vv(idle, 1, 0, 8'h02, 1);                                  // r1 via mem only
    tbl[14] = vv(idle, 1, 0, 8'h00, 1);
    tbl[15] = vv(ins(1, 2, 1, 0, 0, 1, 0, 1, 2, 0, 0), 1, 0, 8'h00, 1); // LD r2,(r2)
    tbl[16] = vv(ins(0, 2, 1, 2, 1, 1, 0, 1, 2, 0, 0), 1, 0, 8'h04, 1); // id_valid=0
    tbl[17] = vv(idle, 1, 0, 8'h04, 1);
    tbl[18] = vv(ins(1, 0, 1, 0, 0, 1, 0, 1, 5, 0, 0), 1, 0, 8'h00, 1); // LD r5
    tbl[19] = vv(ins(1, 6, 1, 0, 0, 1, 0, 1, 5, 0, 0), 1, 0, 8'h20, 1); // LD r5 again
    tbl[20] = vv(ins(1, 1, 1, 5, 1, 1, 0, 0, 1, 0, 0), 1, 1, 8'h20, 1); // ADD r1,r1,r5
    tbl[21] = vv(ins(1, 1, 1, 5, 1, 1, 0, 0, 1, 0, 0), 1, 0, 8'h20, 2); // MEM ignored
    tbl[22] = vv(idle, 1, 0, 8'h02, 2);
    tbl[23] = vv(ins(1, 0, 1, 0, 0, 1, 0, 1, 4, 0, 0), 1, 0, 8'h02, 2); // LD r4
    tbl[24] = vv(ins(1, 0, 1, 4, 0, 1, 0, 0, 6, 0, 0), 1, 0, 8'h10, 2); // Rt=r4 unread
    tbl[25] = vv(ins(1, 0, 1, 0, 0, 1, 0, 1, 7, 0, 0), 1, 0, 8'h50, 2); // LD r7
    tbl[26] = vv(ins(1, 7, 1, 0, 0, 1, 0, 0, 1, 0, 1), 0, 0, 8'h00, 0); // reset mid-hazard
    tbl[27] = vv(ins(1, 7, 1, 0, 0, 1, 0, 0, 1, 0, 0), 1, 0, 8'h00, 0); // no residual

    // reset both instances for two cycles
    repeat (2) @(negedge clk);

    for (int k = 0; k < 28; k++) begin
      step1(tbl[k], $sformatf("v%0d", k));
    end

    // ---- FORWARD=0: XOR r2 then BEQZ r2 stalls exactly 2 cycles ----
    beqz = ins(1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step0(idle, 1, 0, 8'h00, 4'd0, "f0 reset");
    step0(ins(1, 1, 1, 3, 1, 1, 0, 0, 2, 0, 0), 1, 0, 8'h00, 4'd0, "xor");
    step0(beqz, 1, 1, 8'h04, 4'd0, "beqz ex");
    step0(beqz, 1, 1, 8'h04, 4'd1, "beqz mem");
    step0(beqz, 1, 0, 8'h00, 4'd2, "beqz wb");
    step0(idle, 1, 0, 8'h00, 4'd2, "f0 idle");

    // ---- FORWARD=0: repeated self-dependent writer saturates the 4-bit counter
    // Pattern per 3 cycles: insert, stall (EX), stall (MEM) -> 40 stalls in 60.
    hz = ins(1, 3, 1, 0, 0, 1, 0, 0, 3, 0, 0);
    for (int n = 0; n < 60; n++) begin
      step0(hz, 0, 0, 8'h00, 4'd0, "sat");
    end
    step0(ins(1, 3, 1, 0, 0, 1, 0, 0, 3, 0, 1), 0, 0, 8'h00, 4'd0, "sat rst");
    exp_q.push_back(32'hF);
    check("sat cnt", {28'd0, cnt0});
    step0(hz, 1, 0, 8'h00, 4'd0, "post rst");
    step0(hz, 1, 1, 8'h08, 4'd0, "post rst hz");

    // ---- FORWARD=0: flush beats a MEM hazard ----
    step0(ins(1, 3, 1, 0, 0, 1, 0, 0, 3, 1, 0), 1, 0, 8'h08, 4'd1, "f0 flush");
    step0(idle, 1, 0, 8'h00, 4'd1, "f0 squashed");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
